// File: rtl/latch_bank_arb.sv
// latch_bank_arb
// Four-requester round-robin arbiter in front of a bank of NREG
// enable-loaded data registers. A granted requester's address and data are
// captured in IDLE, and the write lands at the edge that ends WRITE. The
// one-hot ack pulse during WRITE tells the requester that its word was taken.
//
// Optional feature: define LATCH_BANK_ARB_LOCK_EN to compile in burst lock.
// With it, a granted requester holding lock and req keeps the grant and gets
// one write per cycle. Without it, the lock input is ignored and every write
// takes an IDLE/WRITE pair.
module latch_bank_arb #(
    parameter int DW   = 16,
    parameter int NREG = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [11:0]          addr,
    input  logic [4*DW-1:0]      wdata,
    input  logic [3:0]           lock,
    output logic [3:0]           ack,
    output logic [NREG*DW-1:0]   q,
    output logic                 busy
);

    // Controller states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    // Round-robin pick: the first requesting index after ptr, wrapping mod 4.
    // The k = 4 step wraps back onto ptr itself, so ptr has the lowest priority.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [3:0] rq);
        logic [1:0] idx;
        logic       found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && rq[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    // One-hot decode of a requester index
    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        onehot4 = 4'b0001 << idx;
    endfunction

    // Controller registers
    logic [0:0]    r_state;
    logic [1:0]    r_ptr;
    logic [1:0]    r_g;
    logic [2:0]    r_addr;
    logic [DW-1:0] r_wdata;
    logic [3:0]    r_ack;
    logic          r_busy;

    // Register bank
    logic [DW-1:0] r_lat [NREG];

    // Combinational helpers
    logic [1:0]    w_win;
    logic [1:0]    w_sel_idx;
    logic [2:0]    w_addr_sel;
    logic [DW-1:0] w_wdata_sel;
    logic          w_burst;

`ifdef LATCH_BANK_ARB_LOCK_EN
    // Burst continues only while the current grantee keeps both lock and req high
    assign w_burst = lock[r_g] & req[r_g];
`else
    // Lock feature compiled out: fold the input into a sink so it stays visibly unused
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
    assign w_burst       = 1'b0;
`endif

    // Winner selection for the next grant
    assign w_win = rr_pick(r_ptr, req);

    // Capture mux: the arbitration winner in IDLE, the current grantee in WRITE (next burst word)
    always_comb begin
        w_sel_idx   = 2'd0;
        w_addr_sel  = 3'd0;
        w_wdata_sel = '0;
        if (r_state == ST_WRITE) begin
            w_sel_idx = r_g;
        end else begin
            w_sel_idx = w_win;
        end
        w_addr_sel  = addr[3*w_sel_idx +: 3];
        w_wdata_sel = wdata[DW*w_sel_idx +: DW];
    end

    // IDLE/WRITE controller: grant capture, ack/busy generation and pointer update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= 2'd3;
            r_g     <= 2'd0;
            r_addr  <= 3'd0;
            r_wdata <= '0;
            r_ack   <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_state <= ST_WRITE;
                        r_g     <= w_win;
                        r_addr  <= w_addr_sel;
                        r_wdata <= w_wdata_sel;
                        r_ack   <= onehot4(w_win);
                        r_busy  <= 1'b1;
                    end else begin
                        r_ack   <= 4'b0000;
                        r_busy  <= 1'b0;
                    end
                end
                ST_WRITE: begin
                    if (w_burst) begin
                        // Keep the grant; ptr stays put until the burst ends
                        r_addr  <= w_addr_sel;
                        r_wdata <= w_wdata_sel;
                        r_ack   <= onehot4(r_g);
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_g;
                        r_ack   <= 4'b0000;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ack   <= 4'b0000;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Bank update: the addressed register loads at the end of each WRITE cycle.
    // Out-of-range addresses match no register, so the write is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int n = 0; n < NREG; n++) begin
                r_lat[n] <= '0;
            end
        end else begin
            for (int n = 0; n < NREG; n++) begin
                if ((r_state == ST_WRITE) && (r_addr == 3'(n))) begin
                    r_lat[n] <= r_wdata;
                end else begin
                    r_lat[n] <= r_lat[n];
                end
            end
        end
    end

    // Packed view of the bank
    genvar gn;
    generate
        for (gn = 0; gn < NREG; gn++) begin : g_q
            assign q[DW*gn +: DW] = r_lat[gn];
        end
    endgenerate

    assign ack  = r_ack;
    assign busy = r_busy;

endmodule
